// File: rtl/smbm_sched.sv
// smbm_sched: round-robin ADD/DELETE/READ scheduler in front of a single smbm.
// One operation in flight; illegal operations are answered without issuing.
// Optional define SMBM_SCHED_ID_TRACK_EN keeps an id presence bitmap and
// answers ADD of a present id / DELETE of an absent id with ID_ERR.
module smbm_sched #(
  parameter int NUM_REQ            = 4,
  parameter int REQ_LOG            = 2,
  parameter int BIT_VEC_SIZE       = 512,
  parameter int BIT_VEC_SIZE_LOG   = 9,
  parameter int NUM_OF_METRICS     = 4,
  parameter int NUM_OF_METRICS_LOG = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_REQ-1:0]                           req_valid,
  output logic [NUM_REQ-1:0]                           req_ready,
  input  logic [NUM_REQ-1:0][1:0]                      req_op,
  input  logic [NUM_REQ-1:0][BIT_VEC_SIZE_LOG-1:0]     req_id,
  input  logic [NUM_REQ-1:0][NUM_OF_METRICS-1:0][7:0]  req_metric,
  input  logic [NUM_REQ-1:0][BIT_VEC_SIZE-1:0]         req_in,
  input  logic [NUM_REQ-1:0][NUM_OF_METRICS_LOG-1:0]   req_metricX,
  output logic [2:0]                                   sm_opcode,
  output logic [2:0]                                   sm_opcode_in,
  output logic [BIT_VEC_SIZE_LOG-1:0]                  sm_id,
  output logic [NUM_OF_METRICS-1:0][7:0]               sm_metric_val,
  output logic [BIT_VEC_SIZE-1:0]                      sm_in,
  output logic [NUM_OF_METRICS_LOG-1:0]                sm_metricX,
  input  logic                                         sm_done,
  output logic                                         rsp_valid,
  input  logic                                         rsp_ready,
  output logic [REQ_LOG-1:0]                           rsp_req,
  output logic [1:0]                                   rsp_status,
  output logic [BIT_VEC_SIZE_LOG:0]                    occupancy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] OP_ADD = 2'd0, OP_DEL = 2'd1, OP_READ = 2'd2, OP_READ_ALL = 2'd3;
  localparam logic [1:0] ST_OK = 2'd0, ST_FULL = 2'd1, ST_EMPTY = 2'd2, ST_ID_ERR = 2'd3;
  localparam logic [BIT_VEC_SIZE_LOG:0] OCC_MAX = (BIT_VEC_SIZE_LOG+1)'(BIT_VEC_SIZE);

  state_t                              r_state, w_state_next;
  logic [REQ_LOG-1:0]                  r_rr_ptr;
  logic [1:0]                          r_op;
  logic [2:0]                          r_opcode_in;
  logic [BIT_VEC_SIZE_LOG-1:0]         r_id;
  logic [NUM_OF_METRICS-1:0][7:0]      r_metric;
  logic [BIT_VEC_SIZE-1:0]             r_in;
  logic [NUM_OF_METRICS_LOG-1:0]       r_metricX;
  logic [REQ_LOG-1:0]                  r_rsp_req;
  logic [1:0]                          r_rsp_status;
  logic [BIT_VEC_SIZE_LOG:0]           r_occupancy;

  logic                                w_grant_vld;
  logic [REQ_LOG-1:0]                  w_grant;
  logic [1:0]                          w_gnt_op;
  logic [BIT_VEC_SIZE_LOG-1:0]         w_gnt_id;
  logic                                w_rej;
  logic [1:0]                          w_rej_status;
  logic                                w_accept;

  // Reduce an index sum (at most 2*NUM_REQ-2) modulo NUM_REQ.
  function automatic logic [REQ_LOG-1:0] f_wrap(input logic [REQ_LOG:0] s);
    logic [REQ_LOG:0] t;
    t = (s >= (REQ_LOG+1)'(NUM_REQ)) ? (s - (REQ_LOG+1)'(NUM_REQ)) : s;
    return t[REQ_LOG-1:0];
  endfunction

  // Round-robin pick: first valid requester at or after r_rr_ptr, with wrap.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[f_wrap({1'b0, r_rr_ptr} + (REQ_LOG+1)'(k))]) begin
        w_grant_vld = 1'b1;
        w_grant     = f_wrap({1'b0, r_rr_ptr} + (REQ_LOG+1)'(k));
      end
    end
  end

  assign w_gnt_op = req_op[w_grant];
  assign w_gnt_id = req_id[w_grant];
  assign w_accept = (r_state == S_IDLE) && w_grant_vld;

`ifdef SMBM_SCHED_ID_TRACK_EN
  logic [BIT_VEC_SIZE-1:0] r_present;

  // Presence bitmap follows completed ADD/DELETE operations.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_present <= '0;
    end else if (r_state == S_WAIT && sm_done) begin
      if (r_op == OP_ADD) r_present[r_id] <= 1'b1;
      else if (r_op == OP_DEL) r_present[r_id] <= 1'b0;
    end
  end
`endif

  // Legality of the request being granted; capacity checks win over id checks.
  always_comb begin
    w_rej        = 1'b0;
    w_rej_status = ST_OK;
    if (w_gnt_op == OP_ADD && r_occupancy == OCC_MAX) begin
      w_rej = 1'b1; w_rej_status = ST_FULL;
    end else if (w_gnt_op == OP_DEL && r_occupancy == '0) begin
      w_rej = 1'b1; w_rej_status = ST_EMPTY;
`ifdef SMBM_SCHED_ID_TRACK_EN
    end else if (w_gnt_op == OP_ADD && r_present[w_gnt_id]) begin
      w_rej = 1'b1; w_rej_status = ST_ID_ERR;
    end else if (w_gnt_op == OP_DEL && !r_present[w_gnt_id]) begin
      w_rej = 1'b1; w_rej_status = ST_ID_ERR;
`endif
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state logic: rejected requests skip straight to the response.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_vld) w_state_next = w_rej ? S_RESP : S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (sm_done) w_state_next = S_RESP;
      S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state: grant strobe, one-cycle opcode, response valid.
  always_comb begin
    req_ready = '0;
    sm_opcode = 3'b111;
    rsp_valid = 1'b0;
    if (w_accept) req_ready[w_grant] = 1'b1;
    if (r_state == S_ISSUE) begin
      case (r_op)
        OP_ADD:  sm_opcode = 3'b000;
        OP_DEL:  sm_opcode = 3'b001;
        default: sm_opcode = 3'b010;
      endcase
    end
    if (r_state == S_RESP) rsp_valid = 1'b1;
  end

  // Latch the granted request; arguments stay put until the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr     <= '0;
      r_op         <= OP_ADD;
      r_opcode_in  <= 3'b000;
      r_id         <= '0;
      r_metric     <= '0;
      r_in         <= '0;
      r_metricX    <= '0;
      r_rsp_req    <= '0;
      r_rsp_status <= ST_OK;
    end else if (w_accept) begin
      r_rr_ptr     <= f_wrap({1'b0, w_grant} + (REQ_LOG+1)'(1));
      r_op         <= w_gnt_op;
      r_opcode_in  <= (w_gnt_op == OP_READ) ? 3'b010 :
                      (w_gnt_op == OP_READ_ALL) ? 3'b101 : 3'b000;
      r_id         <= w_gnt_id;
      r_metric     <= req_metric[w_grant];
      r_in         <= req_in[w_grant];
      r_metricX    <= req_metricX[w_grant];
      r_rsp_req    <= w_grant;
      r_rsp_status <= w_rej ? w_rej_status : ST_OK;
    end
  end

  // Occupancy moves only when smbm completes an ADD or DELETE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occupancy <= '0;
    end else if (r_state == S_WAIT && sm_done) begin
      if (r_op == OP_ADD)      r_occupancy <= r_occupancy + 1'b1;
      else if (r_op == OP_DEL) r_occupancy <= r_occupancy - 1'b1;
    end
  end

  assign sm_opcode_in  = r_opcode_in;
  assign sm_id         = r_id;
  assign sm_metric_val = r_metric;
  assign sm_in         = r_in;
  assign sm_metricX    = r_metricX;
  assign rsp_req       = r_rsp_req;
  assign rsp_status    = r_rsp_status;
  assign occupancy     = r_occupancy;

endmodule

// File: tb/tb_smbm_sched.sv
// Self-checking bench for smbm_sched with a scoreboard of expected responses
// and a small smbm stand-in that answers done after a fixed delay.
module tb_smbm_sched;
  localparam int N = 4, RL = 2, BVS = 512, BVL = 9, NM = 4, NML = 2;
  localparam logic [1:0] ADD = 2'd0, DEL = 2'd1, RD = 2'd2, RDA = 2'd3;
  localparam logic [1:0] OK = 2'd0, FULL = 2'd1, EMPTY = 2'd2, IDERR = 2'd3;

  logic clk, rst;
  logic [N-1:0]              req_valid, req_ready;
  logic [N-1:0][1:0]         req_op;
  logic [N-1:0][BVL-1:0]     req_id;
  logic [N-1:0][NM-1:0][7:0] req_metric;
  logic [N-1:0][BVS-1:0]     req_in;
  logic [N-1:0][NML-1:0]     req_metricX;
  logic [2:0]                sm_opcode, sm_opcode_in;
  logic [BVL-1:0]            sm_id;
  logic [NM-1:0][7:0]        sm_metric_val;
  logic [BVS-1:0]            sm_in;
  logic [NML-1:0]            sm_metricX;
  logic                      sm_done, rsp_valid, rsp_ready;
  logic [RL-1:0]             rsp_req;
  logic [1:0]                rsp_status;
  logic [BVL:0]              occupancy;

  smbm_sched #(.NUM_REQ(N), .REQ_LOG(RL), .BIT_VEC_SIZE(BVS), .BIT_VEC_SIZE_LOG(BVL),
               .NUM_OF_METRICS(NM), .NUM_OF_METRICS_LOG(NML)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_id(req_id), .req_metric(req_metric), .req_in(req_in),
    .req_metricX(req_metricX), .sm_opcode(sm_opcode), .sm_opcode_in(sm_opcode_in),
    .sm_id(sm_id), .sm_metric_val(sm_metric_val), .sm_in(sm_in), .sm_metricX(sm_metricX),
    .sm_done(sm_done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_req(rsp_req),
    .rsp_status(rsp_status), .occupancy(occupancy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int issue_cnt = 0, issue_cyc = 0;
  logic [2:0] issue_op = 3'b111, issue_opin = 3'b000;
  int exp_occ = 0;

  typedef struct packed { logic [1:0] req; logic [1:0] status; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // smbm stand-in: ADD/DELETE complete 2 cycles after issue, READ after 1.
  int unsigned mdl_cnt;
  logic extra_done;
  always @(posedge clk or negedge rst) begin
    if (!rst) mdl_cnt <= 0;
    else if (mdl_cnt != 0) mdl_cnt <= mdl_cnt - 1;
    else if (sm_opcode == 3'b000 || sm_opcode == 3'b001) mdl_cnt <= 2;
    else if (sm_opcode == 3'b010) mdl_cnt <= 1;
  end
  assign sm_done = (mdl_cnt == 1) || extra_done;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: grant sanity, issue tracking and scoreboard pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      check_val("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      if (sm_opcode != 3'b111) begin
        issue_cnt  <= issue_cnt + 1;
        issue_cyc  <= cyc;
        issue_op   <= sm_opcode;
        issue_opin <= sm_opcode_in;
      end
      if (rsp_valid && rsp_ready) begin
        $display("rsp req=%0d status=%0d occ=%0d cycle=%0d", rsp_req, rsp_status, occupancy, cyc);
        if (sb_q.size() == 0) begin
          check_val("sb_unexpected_rsp", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check_val("rsp_req", 64'(rsp_req), 64'(mon_e.req));
          check_val("rsp_status", 64'(rsp_status), 64'(mon_e.status));
        end
      end
    end
  end

  // One request from one requester, checked end to end.
  task automatic run_op(input int idx, input logic [1:0] op, input int id,
                        input logic [31:0] met, input logic [1:0] exp_st, input int exp_lat);
    int t0, ic0;
    bit got;
    logic [2:0] e_op, e_opin;
    @(posedge clk); #1;
    req_op[idx] = op;
    req_id[idx] = id[BVL-1:0];
    req_metric[idx] = met;
    req_valid[idx] = 1'b1;
    ic0 = issue_cnt;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req_ready[idx]) got = 1'b1;
    end
    check_val("accept", 64'(got), 64'd1);
    if (!got) begin
      req_valid[idx] = 1'b0;
      return;
    end
    t0 = cyc;
    sb_q.push_back('{req: idx[1:0], status: exp_st});
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    check_val("rsp_seen", 64'(got), 64'd1);
    check_val("latency", 64'(cyc - t0), 64'(exp_lat));
    if (exp_st == OK && op == ADD) exp_occ++;
    if (exp_st == OK && op == DEL) exp_occ--;
    check_val("occupancy", 64'(occupancy), 64'(exp_occ));
    if (exp_st == OK) begin
      e_op   = (op == ADD) ? 3'b000 : (op == DEL) ? 3'b001 : 3'b010;
      e_opin = (op == RD) ? 3'b010 : (op == RDA) ? 3'b101 : 3'b000;
      check_val("issue_once", 64'(issue_cnt - ic0), 64'd1);
      check_val("issue_cycle", 64'(issue_cyc - t0), 64'd1);
      check_val("issue_opcode", 64'(issue_op), 64'(e_op));
      if (op == RD || op == RDA) check_val("issue_opcode_in", 64'(issue_opin), 64'(e_opin));
    end else begin
      check_val("no_issue", 64'(issue_cnt - ic0), 64'd0);
    end
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 60 && sb_q.size() != 0; n++) @(negedge clk);
    check_val(tag, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, h;
    bit got;
    logic [RL-1:0] held_req;
    rst = 1'b0; rsp_ready = 1'b1; extra_done = 1'b0;
    req_valid = '0; req_op = '0; req_id = '0; req_metric = '0; req_in = '0; req_metricX = '0;
    repeat (3) @(negedge clk);
    check_val("rst_req_ready", 64'(req_ready), 64'd0);
    check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("rst_rsp_req", 64'(rsp_req), 64'd0);
    check_val("rst_rsp_status", 64'(rsp_status), 64'd0);
    check_val("rst_occupancy", 64'(occupancy), 64'd0);
    check_val("rst_sm_opcode", 64'(sm_opcode), 64'd7);
    check_val("rst_sm_opcode_in", 64'(sm_opcode_in), 64'd0);
    check_val("rst_sm_id", 64'(sm_id), 64'd0);
    check_val("rst_sm_metric", 64'(sm_metric_val), 64'd0);
    rst = 1'b1;

    // ADD id 5 from requester 2 with metrics {10,20,30,40}.
    run_op(2, ADD, 5, {8'd40, 8'd30, 8'd20, 8'd10}, OK, 4);
    check_val("add_sm_id", 64'(sm_id), 64'd5);
    check_val("add_sm_metric", 64'(sm_metric_val), 64'h281E140A);

    // DELETE it, then DELETE on empty is rejected without issue.
    run_op(3, DEL, 5, 32'd0, OK, 4);
    run_op(3, DEL, 5, 32'd0, EMPTY, 1);
    check_val("empty_sm_opcode", 64'(sm_opcode), 64'd7);

    // done outside WAIT is ignored.
    @(posedge clk); #1 extra_done = 1'b1;
    repeat (2) @(negedge clk);
    check_val("spurious_done_occ", 64'(occupancy), 64'd0);
    check_val("spurious_done_rsp", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1 extra_done = 1'b0;

    // All four hold READ: grants 0,1,2,3,0.
    for (int i = 0; i < N; i++) begin
      req_op[i] = RD;
      req_metricX[i] = 2'(3 - i);
      req_in[i] = BVS'(100 + i);
    end
    for (int i = 0; i < 5; i++) sb_q.push_back('{req: 2'(i % N), status: OK});
    @(posedge clk); #1 req_valid = '1;
    cnt = 0;
    for (int n = 0; n < 100 && cnt < 5; n++) begin
      @(negedge clk);
      if (req_ready != '0) cnt++;
    end
    check_val("rr_grants", 64'(cnt), 64'd5);
    @(posedge clk); #1 req_valid = '0;
    drain("rr_drain");
    check_val("rr_opcode_in", 64'(issue_opin), 64'd2);
    check_val("rr_sm_metricX", 64'(sm_metricX), 64'd3);
    check_val("rr_sm_in", 64'(sm_in[15:0]), 64'd100);

    // READ_ALL from requester 1.
    run_op(1, RDA, 0, 32'd0, OK, 3);

    // Duplicate ADD / absent DELETE.
`ifdef SMBM_SCHED_ID_TRACK_EN
    run_op(0, ADD, 7, 32'h01020304, OK, 4);
    run_op(0, ADD, 7, 32'h01020304, IDERR, 1);
    run_op(0, DEL, 9, 32'd0, IDERR, 1);
    check_val("id_occ", 64'(occupancy), 64'd1);
`else
    run_op(0, ADD, 7, 32'h01020304, OK, 4);
    run_op(0, ADD, 7, 32'h01020304, OK, 4);
    run_op(0, DEL, 9, 32'd0, OK, 4);
    check_val("id_occ", 64'(occupancy), 64'd1);
`endif
    run_op(0, DEL, 7, 32'd0, OK, 4);

    // Fill to capacity, then one more ADD is FULL.
    for (int i = 0; i < BVS; i++) run_op(i % N, ADD, i, 32'(i), OK, 4);
    check_val("full_occ", 64'(occupancy), 64'd512);
    run_op(1, ADD, 3, 32'd0, FULL, 1);

    // Back-pressure on the response with requests pending.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_op[0] = RD; req_op[1] = RD;
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    sb_q.push_back('{req: 2'd0, status: OK});
    sb_q.push_back('{req: 2'd1, status: OK});
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    check_val("hold_rsp_seen", 64'(got), 64'd1);
    held_req = rsp_req;
    check_val("hold_first_req", 64'(held_req), 64'd0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check_val("hold_no_ready", 64'(req_ready), 64'd0);
      check_val("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check_val("hold_rsp_req", 64'(rsp_req), 64'(held_req));
      check_val("hold_rsp_status", 64'(rsp_status), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    h = cyc;
    check_val("hs_cycle_no_ready", 64'(req_ready), 64'd0);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req_ready[1]) got = 1'b1;
    end
    check_val("next_accept_seen", 64'(got), 64'd1);
    check_val("next_accept_cycle", 64'(cyc - h), 64'd1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    drain("hold_drain");

    // Reset while an operation sits in WAIT.
    @(posedge clk); #1;
    req_op[2] = DEL; req_id[2] = '0; req_valid[2] = 1'b1;
    @(negedge clk);
    check_val("rst_op_accept", 64'(req_ready[2]), 64'd1);
    @(posedge clk); #1 req_valid[2] = 1'b0;
    @(negedge clk);
    check_val("rst_op_issue", 64'(sm_opcode), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("midrst_occ", 64'(occupancy), 64'd0);
    check_val("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("midrst_sm_opcode", 64'(sm_opcode), 64'd7);
    check_val("midrst_rsp_req", 64'(rsp_req), 64'd0);
    check_val("midrst_sm_id", 64'(sm_id), 64'd0);
    @(negedge clk);
    check_val("midrst_occ_edge", 64'(occupancy), 64'd0);
    rst = 1'b1;
    exp_occ = 0;
    run_op(3, ADD, 1, 32'h11223344, OK, 4);

    drain("final_sb_empty");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
